// File: rtl/wb_stage_pkg.sv
// Shared RV32I encodings used by the write-back path.
// Load alignment lives here so other stages can reuse it.
package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        RF_ALU   = 3'd0,
        RF_BR    = 3'd1,
        RF_UIMM  = 3'd2,
        RF_LOAD  = 3'd3,
        RF_PC4   = 3'd4
    } regfilemux_sel_t;

    // Half select uses off[1] only, matching MEM's byte-enable scheme.
    function automatic logic [31:0] align_load(
        input logic [2:0]  funct3,
        input logic [1:0]  off,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            lb:      return {{24{b[7]}}, b};
            lbu:     return {24'h0, b};
            lh:      return {{16{h[15]}}, h};
            lhu:     return {16'h0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/wb_stage_regfile.sv
// 32-entry register file with hardwired x0 and
// write-through bypass on both read ports.
module regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [XLEN-1:0]         in,
    input  logic [$clog2(NREG)-1:0] dest,
    input  logic [$clog2(NREG)-1:0] src_a,
    input  logic [$clog2(NREG)-1:0] src_b,
    output logic [XLEN-1:0]         reg_a,
    output logic [XLEN-1:0]         reg_b
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr;

    assign wr = load && (dest != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (wr) begin
            regs[dest] <= in;
        end
    end

    always_comb begin
        reg_a = '0;
        if (src_a != '0) begin
            reg_a = (wr && src_a == dest) ? in : regs[src_a];
        end
    end

    always_comb begin
        reg_b = '0;
        if (src_b != '0) begin
            reg_b = (wr && src_b == dest) ? in : regs[src_b];
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: load alignment, result mux, register file,
// registered commit port and retired-instruction counter.
module wb_stage
    import rv32i_types::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            wb_valid,
    input  logic            wb_load_regfile,
    input  logic [4:0]      wb_rd,
    input  logic [2:0]      wb_regfilemux_sel,
    input  logic [2:0]      wb_funct3,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] u_imm,
    input  logic [XLEN-1:0] pc,
    input  logic            br_en,
    input  logic [XLEN-1:0] data_value,
    input  logic [1:0]      mem_address_last_two_bits,
    input  logic [4:0]      rs1_idx,
    input  logic [4:0]      rs2_idx,
    output logic [XLEN-1:0] rs1_out,
    output logic [XLEN-1:0] rs2_out,
    output logic            commit_valid,
    output logic [4:0]      commit_rd,
    output logic [XLEN-1:0] commit_data,
    output logic [63:0]     instret
);

    logic            we;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] load_data;

    assign we = wb_valid && wb_load_regfile && !stall
                && (wb_rd != 5'd0);

    assign load_data = align_load(wb_funct3,
                                  mem_address_last_two_bits,
                                  data_value);

    always_comb begin
        wb_data = '0;
        case (wb_regfilemux_sel)
            RF_ALU:  wb_data = alu_out;
            RF_BR:   wb_data = {{(XLEN-1){1'b0}}, br_en};
            RF_UIMM: wb_data = u_imm;
            RF_LOAD: wb_data = load_data;
            RF_PC4:  wb_data = pc + XLEN'(4);
            default: wb_data = '0;
        endcase
    end

    regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .load  (we),
        .in    (wb_data),
        .dest  (wb_rd),
        .src_a (rs1_idx),
        .src_b (rs2_idx),
        .reg_a (rs1_out),
        .reg_b (rs2_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_data  <= '0;
            instret      <= '0;
        end else if (!stall) begin
            commit_valid <= wb_valid;
            commit_rd    <= we ? wb_rd : 5'd0;
            commit_data  <= we ? wb_data : '0;
            if (wb_valid) begin
                instret <= instret + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed and randomized checks of wb_stage against an
// array-based reference of the architectural register file.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        wb_valid;
    logic        wb_load_regfile;
    logic [4:0]  wb_rd;
    logic [2:0]  wb_regfilemux_sel;
    logic [2:0]  wb_funct3;
    logic [31:0] alu_out;
    logic [31:0] u_imm;
    logic [31:0] pc;
    logic        br_en;
    logic [31:0] data_value;
    logic [1:0]  mem_address_last_two_bits;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic [63:0] instret;

    wb_stage dut (
        .clk                       (clk),
        .rst                       (rst),
        .stall                     (stall),
        .wb_valid                  (wb_valid),
        .wb_load_regfile           (wb_load_regfile),
        .wb_rd                     (wb_rd),
        .wb_regfilemux_sel         (wb_regfilemux_sel),
        .wb_funct3                 (wb_funct3),
        .alu_out                   (alu_out),
        .u_imm                     (u_imm),
        .pc                        (pc),
        .br_en                     (br_en),
        .data_value                (data_value),
        .mem_address_last_two_bits (mem_address_last_two_bits),
        .rs1_idx                   (rs1_idx),
        .rs2_idx                   (rs2_idx),
        .rs1_out                   (rs1_out),
        .rs2_out                   (rs2_out),
        .commit_valid              (commit_valid),
        .commit_rd                 (commit_rd),
        .commit_data               (commit_data),
        .instret                   (instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic        m_cv;
    logic [4:0]  m_crd;
    logic [31:0] m_cdata;
    longint unsigned m_instret;
    logic [63:0] snap;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load();
        int sh;
        logic [31:0] bt;
        logic [31:0] hf;
        sh = 8 * int'(mem_address_last_two_bits);
        bt = (data_value >> sh) & 32'hFF;
        hf = mem_address_last_two_bits[1] ? (data_value >> 16)
                                          : (data_value & 32'hFFFF);
        case (wb_funct3)
            3'd0: return (bt >= 32'h80) ? bt - 32'h100 : bt;
            3'd4: return bt;
            3'd1: return (hf >= 32'h8000) ? hf - 32'h10000 : hf;
            3'd5: return hf & 32'hFFFF;
            default: return data_value;
        endcase
    endfunction

    function automatic logic [31:0] ref_data();
        case (wb_regfilemux_sel)
            3'd0: return alu_out;
            3'd1: return br_en ? 32'd1 : 32'd0;
            3'd2: return u_imm;
            3'd3: return ref_load();
            3'd4: return 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx,
                                             input logic wr,
                                             input logic [31:0] d);
        if (idx == 5'd0) return 32'd0;
        if (wr && idx == wb_rd) return d;
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cv = 1'b0;
        m_crd = 5'd0;
        m_cdata = 32'd0;
        m_instret = 0;
    endtask

    task automatic idle();
        stall = 0; wb_valid = 0; wb_load_regfile = 0;
        wb_rd = 0; wb_regfilemux_sel = 0; wb_funct3 = 0;
        alu_out = 0; u_imm = 0; pc = 0; br_en = 0;
        data_value = 0; mem_address_last_two_bits = 0;
        rs1_idx = 0; rs2_idx = 0;
    endtask

    // Inputs are already applied; check reads, clock, check commit.
    task automatic cycle();
        logic wr;
        logic [31:0] d;
        wr = wb_valid && wb_load_regfile && !stall && wb_rd != 0;
        d = ref_data();
        #1;
        check("rs1_out", 64'(rs1_out), 64'(ref_read(rs1_idx, wr, d)));
        check("rs2_out", 64'(rs2_out), 64'(ref_read(rs2_idx, wr, d)));
        @(posedge clk);
        #1;
        if (wr) m_regs[wb_rd] = d;
        if (!stall) begin
            m_cv = wb_valid;
            m_crd = wr ? wb_rd : 5'd0;
            m_cdata = wr ? d : 32'd0;
            if (wb_valid) m_instret = m_instret + 1;
        end
        check("commit_valid", 64'(commit_valid), 64'(m_cv));
        check("commit_rd", 64'(commit_rd), 64'(m_crd));
        check("commit_data", 64'(commit_data), 64'(m_cdata));
        check("instret", instret, 64'(m_instret));
    endtask

    task automatic write_alu(input logic [4:0] rd, input logic [31:0] v);
        idle();
        wb_valid = 1; wb_load_regfile = 1; wb_rd = rd; alu_out = v;
        cycle();
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [1:0] off);
        idle();
        wb_valid = 1; wb_load_regfile = 1; wb_rd = 5'd3;
        wb_regfilemux_sel = 3'd3; wb_funct3 = f3;
        data_value = 32'h80FF7F01;
        mem_address_last_two_bits = off;
        cycle();
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1;
        #1;
        check("reset_instret", instret, 64'd0);
        check("reset_commit_valid", 64'(commit_valid), 64'd0);
        check("reset_rs1", 64'(rs1_out), 64'd0);
        #3 rst = 0;
        @(posedge clk);
        #1;

        // asynchronous reset between edges
        write_alu(5'd5, 32'h1234);
        idle();
        rs1_idx = 5'd5;
        #1;
        check("preload_x5", 64'(rs1_out), 64'h1234);
        #1 rst = 1;
        #1;
        check("async_rst_rs1", 64'(rs1_out), 64'd0);
        check("async_rst_instret", instret, 64'd0);
        check("async_rst_commit_data", 64'(commit_data), 64'd0);
        model_reset();
        #1 rst = 0;
        @(posedge clk);
        #1;

        // load alignment
        do_load(3'd0, 2'd1);
        check("lb_off1", 64'(commit_data), 64'h0000007F);
        do_load(3'd0, 2'd3);
        check("lb_off3", 64'(commit_data), 64'hFFFFFF80);
        do_load(3'd4, 2'd3);
        check("lbu_off3", 64'(commit_data), 64'h00000080);
        do_load(3'd1, 2'd2);
        check("lh_off2", 64'(commit_data), 64'hFFFF80FF);
        do_load(3'd5, 2'd0);
        check("lhu_off0", 64'(commit_data), 64'h00007F01);
        do_load(3'd1, 2'd1);
        check("lh_off1", 64'(commit_data), 64'h00007F01);
        do_load(3'd2, 2'd3);
        check("lw_off3", 64'(commit_data), 64'h80FF7F01);

        // bypass on both ports
        idle();
        wb_valid = 1; wb_load_regfile = 1; wb_rd = 5'd7;
        alu_out = 32'hDEADBEEF; rs1_idx = 5'd7; rs2_idx = 5'd7;
        #1;
        check("bypass_rs1", 64'(rs1_out), 64'hDEADBEEF);
        check("bypass_rs2", 64'(rs2_out), 64'hDEADBEEF);
        cycle();
        idle();
        rs1_idx = 5'd7; rs2_idx = 5'd7;
        #1;
        check("array_rs1", 64'(rs1_out), 64'hDEADBEEF);
        check("array_rs2", 64'(rs2_out), 64'hDEADBEEF);
        cycle();

        // x0 protection
        snap = instret;
        idle();
        wb_valid = 1; wb_load_regfile = 1; wb_rd = 5'd0;
        alu_out = 32'hFFFFFFFF;
        cycle();
        check("x0_commit_rd", 64'(commit_rd), 64'd0);
        check("x0_instret", instret, snap + 64'd1);
        check("x0_read", 64'(rs1_out), 64'd0);

        // stall holds everything
        snap = instret;
        idle();
        stall = 1; wb_valid = 1; wb_load_regfile = 1;
        wb_rd = 5'd9; alu_out = 32'h5A5A1234; rs1_idx = 5'd9;
        repeat (3) cycle();
        check("stall_instret", instret, snap);
        check("stall_x9", 64'(rs1_out), 64'd0);
        stall = 0;
        cycle();
        check("release_instret", instret, snap + 64'd1);
        check("release_commit", 64'(commit_data), 64'h5A5A1234);
        idle();
        rs1_idx = 5'd9;
        #1;
        check("release_x9", 64'(rs1_out), 64'h5A5A1234);

        // mux sources
        idle();
        wb_valid = 1; wb_load_regfile = 1; wb_rd = 5'd10;
        wb_regfilemux_sel = 3'd1; br_en = 1;
        cycle();
        check("mux_br", 64'(commit_data), 64'h1);
        wb_regfilemux_sel = 3'd4; pc = 32'hFFFFFFFC;
        cycle();
        check("mux_pc4", 64'(commit_data), 64'h0);
        wb_regfilemux_sel = 3'd2; u_imm = 32'hABCDE000;
        cycle();
        check("mux_uimm", 64'(commit_data), 64'hABCDE000);
        wb_regfilemux_sel = 3'd6;
        cycle();
        check("mux_reserved", 64'(commit_data), 64'h0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            stall = ($urandom_range(0, 3) == 0);
            wb_valid = $urandom_range(0, 1);
            wb_load_regfile = ($urandom_range(0, 3) != 0);
            wb_rd = 5'($urandom_range(0, 31));
            wb_regfilemux_sel = 3'($urandom_range(0, 7));
            wb_funct3 = 3'($urandom_range(0, 7));
            alu_out = $urandom;
            u_imm = $urandom;
            pc = $urandom;
            br_en = $urandom_range(0, 1);
            data_value = $urandom;
            mem_address_last_two_bits = 2'($urandom_range(0, 3));
            rs1_idx = ($urandom_range(0, 2) == 0) ? wb_rd
                                                  : 5'($urandom_range(0, 31));
            rs2_idx = ($urandom_range(0, 2) == 0) ? wb_rd
                                                  : 5'($urandom_range(0, 31));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage RV32I pipeline, directly downstream of `MEM_stage`. Consumes the registered load word `data_value` and `mem_address_last_two_bits`, and aligns and extends load data per `funct3`. Selects the write-back value, writes the 32×32 register file it owns, and serves the decode-stage read ports with same-cycle write bypass. Also produces a registered commit port and a 64-bit retired-instruction counter for forwarding and RVFI.

## Interface
Parameters
- `XLEN`, 32, datapath width
- `NREG`, 32, register count; x0 is hardwired to zero

Ports
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `stall` in 1: pipeline hold; suppresses all state updates
- `wb_valid` in 1: the instruction in WB is real, not a bubble
- `wb_load_regfile` in 1: the instruction writes `rd`
- `wb_rd` in 5: destination index
- `wb_regfilemux_sel` in 3: 0=`alu_out`, 1=`br_en`, 2=`u_imm`, 3=load, 4=`pc`+4; 5–7 reserved (write 0)
- `wb_funct3` in 3: load type
- `alu_out`, `u_imm`, `pc` in 32: write-back sources
- `br_en` in 1: comparison result
- `data_value` in 32: load word from `MEM_stage`
- `mem_address_last_two_bits` in 2: byte offset from `MEM_stage`
- `rs1_idx`, `rs2_idx` in 5: decode read indices
- `rs1_out`, `rs2_out` out 32: decode read data
- `commit_valid` out 1, `commit_rd` out 5, `commit_data` out 32: registered commit
- `instret` out 64: count of retired instructions

## Operation
- Write enable: `we` = `wb_valid` & `wb_load_regfile` & !`stall` & (`wb_rd`≠0).
- Load alignment, with `off` = `mem_address_last_two_bits`:
  - lb: sign-extend byte `off`.
  - lbu: zero-extend byte `off`.
  - lh: sign-extend the half selected by `off[1]`. Offsets 01 and 11 use the low and high half respectively, matching the MEM byte-enable convention.
  - lhu: as lh, but zero-extended.
  - lw: pass `data_value` through; `off` is ignored.
  - `funct3` 3, 6, 7: pass `data_value` through.
- `br_en` is zero-extended to 32 bits. `pc`+4 wraps modulo 2^32.
- Register file:
  - On a rising edge with `we`, `regs[wb_rd]` ← `wb_data`.
  - Entry 0 is never written and always reads 0.
- Read ports are combinational. If `rsN_idx` = `wb_rd`, `we` = 1 and `rsN_idx` ≠ 0, then `rsN_out` = `wb_data` (write-through bypass). Otherwise `rsN_out` = `regs[rsN_idx]`.
- Commit register, on a rising edge:
  - When !`stall`, load `commit_valid` ← `wb_valid`, `commit_rd` ← (`we` ? `wb_rd` : 0) and `commit_data` ← (`we` ? `wb_data` : 0).
  - When `stall`, hold all commit fields.
- `instret` increments by 1 on each edge with `wb_valid` & !`stall`, whether or not the instruction writes a register. It wraps from 2^64−1 to 0.

## Timing
- Reset, asynchronous: all regs, `commit_*` and `instret` clear to 0 immediately on `rst` assertion, with no clock needed. Reset mid-stall behaves the same way. `rs*_out` then read 0.
- Register write latency: data is visible in `regs` one edge after `we`. A same-cycle read returns the new value through the bypass.
- Commit port: one-cycle latency from WB; holds during `stall`.
- Both read ports may hit the same `wb_rd` simultaneously; both are bypassed.
- `wb_rd`=0 with `wb_load_regfile`=1: no write, no bypass, and `commit_rd`=0. `instret` still counts the instruction.
- The whole block is reset-clean; there are no X outputs after reset.

## Structure
- Add `regfilemux_sel_t` (5 encodings) to `rv32i_types` next to `load_funct3_t` and `store_funct3_t`. `load_funct3_t` supplies the lb/lh/lw/lbu/lhu encodings.
- One sub-module: `regfile`. It holds the 32×32 array, x0 hardwiring and the two bypassed read ports, with ports `clk`, `rst`, `load`, `in`, `dest`, `src_a`, `src_b`, `reg_a`, `reg_b`.
- Alignment, mux, commit register and counter live in `wb_stage`.

## Test plan
- Reset in mid-operation: preload x5=0x1234. Assert `rst` between clock edges; `rs1_idx`=5 must read 0 before the next edge, and `instret`=0.
- Load alignment:
  - `data_value`=0x80FF7F01 with lb at off=1 → x3=0x0000007F; at off=3 → 0xFFFFFF80.
  - lbu at off=3 → 0x00000080.
  - lh at off=2 → 0xFFFF80FF; lhu at off=0 → 0x00007F01.
- Bypass: write x7=0xDEADBEEF with `rs1_idx`=`rs2_idx`=7 in the same cycle → both outputs read 0xDEADBEEF combinationally. One cycle later they still read 0xDEADBEEF from the array.
- x0 protection: `wb_rd`=0 with `alu_out`=0xFFFFFFFF and `we` conditions otherwise met → `rs1_idx`=0 reads 0, `commit_rd`=0, and `instret` increments.
- Stall: with `stall`=1 for 3 cycles and `wb_valid`=1 → no regfile write, `commit_*` and `instret` unchanged. On release, exactly one write occurs and `instret` +1.
- Mux sources:
  - sel=1 with `br_en`=1 → 0x00000001.
  - sel=4 with `pc`=0xFFFFFFFC → 0x00000000.
  - sel=2 with `u_imm`=0xABCDE000 → 0xABCDE000.
